// File: rtl/verifier_sumcheck_round_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// verifier_sumcheck_round_pkg : field constants, modular add, round FSM codes
// Rev 1.0
// ----------------------------------------------------------------------------
package verifier_sumcheck_round_pkg;

  localparam int F_NBITS = 31;
  localparam logic [F_NBITS-1:0] F_Q = 31'h7FFF_FFFF;

  typedef logic [F_NBITS-1:0] felem_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RECV  = 2'd1;
  localparam logic [1:0] ST_MUL   = 2'd2;
  localparam logic [1:0] ST_CHECK = 2'd3;

  // Operands are already reduced, so one conditional subtract suffices.
  function automatic felem_t mod_add(input felem_t a, input felem_t b);
    logic [F_NBITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, F_Q}) s = s - {1'b0, F_Q};
    return s[F_NBITS-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/verifier_sumcheck_round_field_multiplier.sv
`default_nettype none
// ----------------------------------------------------------------------------
// verifier_sumcheck_round_field_multiplier : bit-serial mod-F_Q multiplier
// Rev 1.0
// ----------------------------------------------------------------------------
module verifier_sumcheck_round_field_multiplier
  import verifier_sumcheck_round_pkg::*;
(
  input  logic               clk,
  input  logic               rstb,
  input  logic               en,
  input  logic [F_NBITS-1:0] a,
  input  logic [F_NBITS-1:0] b,
  output logic               ready,
  output logic               ready_pulse,
  output logic [F_NBITS-1:0] c
);

  localparam int CNT_W = $clog2(F_NBITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(F_NBITS - 1);

  logic               busy_q;
  logic               pulse_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [F_NBITS-1:0] a_q;
  logic [F_NBITS-1:0] b_q;
  logic [F_NBITS-1:0] res_q;
  logic [F_NBITS-1:0] w_dbl;
  logic [F_NBITS-1:0] w_step;

  // MSB-first double-and-add; every partial result stays reduced.
  assign w_dbl  = mod_add(res_q, res_q);
  assign w_step = b_q[F_NBITS-1] ? mod_add(w_dbl, a_q) : w_dbl;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      busy_q  <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      pulse_q <= 1'b0;
      if (!busy_q) begin
        if (en) begin
          busy_q <= 1'b1;
          a_q    <= a;
          b_q    <= b;
          res_q  <= '0;
          cnt_q  <= CNT_LAST;
        end
      end else begin
        res_q <= w_step;
        b_q   <= {b_q[F_NBITS-2:0], 1'b0};
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == '0) begin
          busy_q  <= 1'b0;
          pulse_q <= 1'b1;
        end
      end
    end
  end

  assign ready       = ~busy_q;
  assign ready_pulse = pulse_q;
  assign c           = res_q;

endmodule
`default_nettype wire

// File: rtl/verifier_sumcheck_round.sv
`default_nettype none
// ----------------------------------------------------------------------------
// verifier_sumcheck_round : checks h(0)+h(1) against the claim, next claim = h(tau)
// Rev 1.0
// ----------------------------------------------------------------------------
module verifier_sumcheck_round
  import verifier_sumcheck_round_pkg::*;
#(
  parameter int degree     = 2,
  parameter int nRounds    = 6,
  parameter int nRoundBits = $clog2(nRounds + 1)
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  en,
  input  logic                  restart,
  input  logic [F_NBITS-1:0]    claim_in,
  input  logic [F_NBITS-1:0]    tau,
  input  logic [F_NBITS-1:0]    coeff_in,
  input  logic                  coeff_valid,
  output logic                  coeff_ready,
  output logic [F_NBITS-1:0]    claim_out,
  output logic [nRoundBits-1:0] round_count,
  output logic                  pass_pulse,
  output logic                  fail,
  output logic                  layer_done,
  output logic                  ready,
  output logic                  ready_pulse
);

  localparam int K_W = $clog2(degree + 2);
  localparam logic [K_W-1:0]        K_LAST = K_W'(degree);
  localparam logic [nRoundBits-1:0] RC_MAX = nRoundBits'(nRounds);

  logic [1:0]            state_q, state_d;
  logic [K_W-1:0]        k_q, k_d;
  logic [F_NBITS-1:0]    acc_q, acc_d;
  logic [F_NBITS-1:0]    sum_q, sum_d;
  logic [F_NBITS-1:0]    chold_q, chold_d;
  logic [F_NBITS-1:0]    tau_q, tau_d;
  logic [F_NBITS-1:0]    claim_q, claim_d;
  logic [nRoundBits-1:0] rc_q, rc_d;
  logic                  fail_q, fail_d;
  logic                  pass_q, pass_d;
  logic                  en_dly_q;
  logic                  ready_dly_q;

  logic                  w_start;
  logic                  w_xfer;
  logic                  w_mul_en;
  logic                  w_mul_ready;
  logic                  w_mul_done;
  logic [F_NBITS-1:0]    w_mul_c;

  assign w_start     = en & ~en_dly_q;
  assign ready       = (state_q == ST_IDLE) & ~w_start;
  assign ready_pulse = ready & ~ready_dly_q;
  assign coeff_ready = (state_q == ST_RECV) & w_mul_ready;
  assign w_xfer      = coeff_valid & coeff_ready;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    acc_d    = acc_q;
    sum_d    = sum_q;
    chold_d  = chold_q;
    tau_d    = tau_q;
    claim_d  = claim_q;
    rc_d     = rc_q;
    fail_d   = fail_q;
    pass_d   = 1'b0;
    w_mul_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_start) begin
          tau_d   = tau;
          sum_d   = '0;
          k_d     = '0;
          state_d = ST_RECV;
          if (restart) begin
            claim_d = claim_in;
            rc_d    = '0;
            fail_d  = 1'b0;
          end
        end
      end
      ST_RECV: begin
        if (w_xfer) begin
          sum_d   = mod_add(sum_q, coeff_in);
          chold_d = coeff_in;
          if (k_q == '0) begin
            acc_d = coeff_in;
            k_d   = k_q + 1'b1;
          end else begin
            w_mul_en = 1'b1;
            state_d  = ST_MUL;
          end
        end
      end
      ST_MUL: begin
        // Horner step: acc = acc*tau + c_k, with c_k parked in chold.
        if (w_mul_done) begin
          acc_d   = mod_add(w_mul_c, chold_q);
          k_d     = k_q + 1'b1;
          state_d = (k_q == K_LAST) ? ST_CHECK : ST_RECV;
        end
      end
      ST_CHECK: begin
        // sum already holds every coefficient once; adding c_0 again gives h(0)+h(1).
        if (mod_add(sum_q, chold_q) == claim_q) pass_d = 1'b1;
        else                                     fail_d = 1'b1;
        claim_d = acc_q;
        if (rc_q != RC_MAX) rc_d = rc_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      chold_q     <= '0;
      tau_q       <= '0;
      claim_q     <= '0;
      rc_q        <= '0;
      fail_q      <= 1'b0;
      pass_q      <= 1'b0;
      en_dly_q    <= 1'b1;
      ready_dly_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      chold_q     <= chold_d;
      tau_q       <= tau_d;
      claim_q     <= claim_d;
      rc_q        <= rc_d;
      fail_q      <= fail_d;
      pass_q      <= pass_d;
      en_dly_q    <= en;
      ready_dly_q <= ready;
    end
  end

  verifier_sumcheck_round_field_multiplier u_mul (
    .clk         (clk),
    .rstb        (rstb),
    .en          (w_mul_en),
    .a           (acc_q),
    .b           (tau_q),
    .ready       (w_mul_ready),
    .ready_pulse (w_mul_done),
    .c           (w_mul_c)
  );

  assign claim_out   = claim_q;
  assign round_count = rc_q;
  assign pass_pulse  = pass_q;
  assign fail        = fail_q;
  assign layer_done  = (rc_q == RC_MAX);

endmodule
`default_nettype wire
